rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the single write port of mips_regfile between two writeback requesters: A (ALU writeback) and B (memory/load writeback). Each requester has its own small FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFOs into the regfile wr_regnum/wr_data/enable pins, one write per cycle. The block also exports a pending-write bitmask that hazard logic uses to stall reads of registers with queued writes.

Parameters:
DEPTH, 2, entries per requester FIFO; power of two, minimum 2.
CW, 2, occupancy counter width; must satisfy 2^CW > DEPTH.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
a_valid  input  1  requester A presents a write.
a_ready  output  1  A FIFO can accept; equals !a_full && !reset.
a_regnum  input  5  destination register for A.
a_data  input  32  write data for A.
b_valid  input  1  requester B presents a write.
b_ready  output  1  B FIFO can accept; equals !b_full && !reset.
b_regnum  input  5  destination register for B.
b_data  input  32  write data for B.
wr_enable  output  1  drives mips_regfile enable.
wr_regnum  output  5  drives mips_regfile wr_regnum.
wr_data  output  32  drives mips_regfile wr_data.
last_grant  output  1  requester granted most recently: 0 = A, 1 = B.
pending  output  32  bit r = 1 iff a queued write targets register r.

Behaviour:
- Reset (async, any cycle, including mid-drain):
  - both FIFOs empty; read/write pointers and counters cleared.
  - last_grant = 1, so A has priority first.
  - wr_enable, wr_regnum, wr_data, pending all 0.
  - a_ready = b_ready = 0 while reset is high.
  - queued writes are discarded; no regfile write occurs during or after reset for them.
- Enqueue:
  - at posedge, when x_valid && x_ready.
  - if x_regnum == 0, the handshake completes but nothing is enqueued ($0 is hardwired zero).
- No push when full. x_ready is low when count == DEPTH, even if a pop happens that same cycle. There is no pass-through.
- Write port is combinational from the selected FIFO head:
  - wr_enable = A nonempty || B nonempty.
  - Both nonempty: select A if last_grant == 1, else B.
  - One nonempty: select that one.
  - None nonempty: wr_enable = 0, wr_regnum = 0, wr_data = 0.
- Pop:
  - at the same posedge the regfile commits the write (wr_enable high).
  - last_grant takes the selected requester; it is unchanged in idle cycles.
- Latency:
  - a write accepted at edge N is visible on the write port during cycle N..N+1, provided its FIFO was empty and it wins arbitration.
  - it commits in the regfile at edge N+1.
  - worst case with the other FIFO busy: one extra cycle per alternation.
- Simultaneous push and pop on the same FIFO (not full): both take effect; count is unchanged.
- Ordering:
  - FIFO order is preserved within a requester.
  - Across requesters, order is arbitration order. Same-register writes from A and B land in grant order. Requesters that care must serialise externally using pending.
- pending:
  - OR over all valid entries of both FIFOs of the one-hot decode of regnum.
  - bit 0 is always 0.
  - a bit clears in the cycle after the last matching entry pops.
- Fairness: with both FIFOs continuously nonempty, grants strictly alternate A, B, A, B...
- Pointers wrap modulo DEPTH; counters never exceed DEPTH or underflow.

Test Plan:
1. Reset, then A writes reg 2 = 88 with B idle.
   - a_ready = 1; pending = 0x00000004 in the next cycle; wr_enable = 1, wr_regnum = 2, wr_data = 88 for one cycle.
   - regfile reg 2 reads 88 afterwards; pending returns to 0.
2. A and B push in the same cycle: A reg 1 = 0xF, B reg 3 = 0xD.
   - A is written first (last_grant was 1), then B.
   - last_grant sequence 0, 1; pending goes 0x0000000A, then 0x00000008, then 0.
3. Hold a_valid high with B idle.
   - After DEPTH = 2 accepts with no drain possible, a_ready drops only when count == 2.
   - Steady state is one accept and one write per cycle; no entry is lost or duplicated (check data 1, 2, 3, 4 in order).
4. A writes reg 0 = 0x4.
   - The handshake completes, wr_enable stays 0, pending stays 0, and regfile $0 still reads 0.
5. Fill both FIFOs, then assert reset mid-drain.
   - Outputs go 0 asynchronously and a_ready = b_ready = 0.
   - After release, wr_enable stays 0 and the targeted registers keep their pre-queue values.
6. A and B both target reg 5 (A = 0x11, B = 0x22) with last_grant = 0.
   - B commits first, then A; reg 5 = 0x11.
   - pending bit 5 stays set until the second write pops.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the mips_regfile write port between the ALU (A)
// and load (B) writeback queues, with a pending-register mask for hazards.
module rf_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_regnum,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_regnum,
    input  logic [31:0] b_data,
    output logic        wr_enable,
    output logic [4:0]  wr_regnum,
    output logic [31:0] wr_data,
    output logic        last_grant,
    output logic [31:0] pending
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [1:0]       valid_in;
    logic [4:0]       regnum_in [2];
    logic [31:0]      data_in   [2];
    logic [1:0]       ready;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       nonempty;
    logic             sel_b;

    logic [CW-1:0]    cnt  [2];
    logic [PW-1:0]    wp   [2];
    logic [PW-1:0]    rp   [2];
    logic [DEPTH-1:0] vld  [2];
    logic [4:0]       mreg [2][DEPTH];
    logic [31:0]      mdat [2][DEPTH];

    assign valid_in     = {b_valid, a_valid};
    assign regnum_in[0] = a_regnum;
    assign regnum_in[1] = b_regnum;
    assign data_in[0]   = a_data;
    assign data_in[1]   = b_data;
    assign a_ready      = ready[0];
    assign b_ready      = ready[1];

    // Writes to $0 complete the handshake but are dropped here.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (cnt[i] != '0);
            ready[i]    = (cnt[i] != FULL) && !reset;
            push[i]     = valid_in[i] && ready[i] && (regnum_in[i] != 5'd0);
        end
    end

    assign sel_b     = nonempty[1] && (!nonempty[0] || !last_grant);
    assign wr_enable = nonempty[0] || nonempty[1];
    assign pop[0]    = nonempty[0] && !sel_b;
    assign pop[1]    = sel_b;

    always_comb begin
        wr_regnum = 5'd0;
        wr_data   = 32'd0;
        if (sel_b) begin
            wr_regnum = mreg[1][rp[1]];
            wr_data   = mdat[1][rp[1]];
        end else if (nonempty[0]) begin
            wr_regnum = mreg[0][rp[0]];
            wr_data   = mdat[0][rp[0]];
        end
    end

    always_comb begin
        pending = 32'd0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (vld[i][j]) pending[mreg[i][j]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
                wp[i]  <= '0;
                rp[i]  <= '0;
                vld[i] <= '0;
            end
        end else begin
            if (wr_enable) last_grant <= sel_b;
            for (int i = 0; i < 2; i++) begin
                if (pop[i]) begin
                    vld[i][rp[i]] <= 1'b0;
                    rp[i]         <= rp[i] + ONE;
                end
                if (push[i]) begin
                    vld[i][wp[i]] <= 1'b1;
                    wp[i]         <= wp[i] + ONE;
                end
                cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    // Payload storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mreg[i][wp[i]] <= regnum_in[i];
                mdat[i][wp[i]] <= data_in[i];
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: per-requester expected queues and a
// round-robin reference pick the write the DUT must present each cycle.
module tb_rf_write_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_regnum = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_regnum = 5'd0;
    logic [31:0] b_data = 32'd0;
    logic        wr_enable;
    logic [4:0]  wr_regnum;
    logic [31:0] wr_data;
    logic        last_grant;
    logic [31:0] pending;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  started = 0;
    bit  mlg = 1'b1;

    rf_write_arbiter #(.DEPTH(DEPTH), .CW(2)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_regnum(a_regnum), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_regnum(b_regnum), .b_data(b_data),
        .wr_enable(wr_enable), .wr_regnum(wr_regnum),
        .wr_data(wr_data), .last_grant(last_grant),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each cycle's write port against the reference pick.
    initial begin : monitor
        logic [31:0] ep;
        wr_t         e;
        bit          gb;
        forever begin
            @(negedge clk);
            if (started) begin
                if (reset) begin
                    qa.delete();
                    qb.delete();
                    mlg = 1'b1;
                    chk("rst_wr_enable", 32'(wr_enable), 32'd0);
                    chk("rst_wr_data", wr_data, 32'd0);
                    chk("rst_pending", pending, 32'd0);
                    chk("rst_a_ready", 32'(a_ready), 32'd0);
                    chk("rst_b_ready", 32'(b_ready), 32'd0);
                    chk("rst_last_grant", 32'(last_grant), 32'd1);
                end else begin
                    ep = 32'd0;
                    foreach (qa[i]) ep[qa[i].r] = 1'b1;
                    foreach (qb[i]) ep[qb[i].r] = 1'b1;
                    chk("pending", pending, ep);
                    chk("a_ready", 32'(a_ready), 32'(qa.size() < DEPTH));
                    chk("b_ready", 32'(b_ready), 32'(qb.size() < DEPTH));
                    chk("last_grant", 32'(last_grant), 32'(mlg));
                    if (qa.size() != 0 || qb.size() != 0) begin
                        gb = (qb.size() != 0) && (qa.size() == 0 || !mlg);
                        e = gb ? qb.pop_front() : qa.pop_front();
                        mlg = gb;
                        chk("wr_enable", 32'(wr_enable), 32'd1);
                        chk("wr_regnum", 32'(wr_regnum), 32'(e.r));
                        chk("wr_data", wr_data, e.d);
                    end else begin
                        chk("idle_wr_enable", 32'(wr_enable), 32'd0);
                        chk("idle_wr_regnum", 32'(wr_regnum), 32'd0);
                        chk("idle_wr_data", wr_data, 32'd0);
                    end
                end
            end
        end
    end

    task automatic step(input bit av, input logic [4:0] ar,
                        input logic [31:0] ad, input bit bv,
                        input logic [4:0] br, input logic [31:0] bd,
                        input bit rs);
        @(negedge clk);
        #1;
        a_valid  = av;
        a_regnum = ar;
        a_data   = ad;
        b_valid  = bv;
        b_regnum = br;
        b_data   = bd;
        if (rs && !reset) begin
            reset = 1'b1;
            #1;
            chk("async_wr_enable", 32'(wr_enable), 32'd0);
            chk("async_wr_regnum", 32'(wr_regnum), 32'd0);
            chk("async_pending", pending, 32'd0);
            chk("async_ready", 32'({a_ready, b_ready}), 32'd0);
        end else begin
            reset = rs;
            #1;
        end
        if (!reset) begin
            if (av && a_ready && ar != 5'd0) qa.push_back('{r: ar, d: ad});
            if (bv && b_ready && br != 5'd0) qb.push_back('{r: br, d: bd});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
    endtask

    initial begin : driver
        int  rst_left;
        bit  rs;
        bit  av;
        bit  bv;
        logic [4:0] ar;
        logic [4:0] br;
        #2 reset = 1'b1;
        started = 1;
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        idle(1);
        // single A write, B idle
        step(1, 5'd2, 32'd88, 0, 5'd0, 32'd0, 0);
        idle(3);
        // simultaneous A and B after reset-priority to A
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        idle(1);
        step(1, 5'd1, 32'hF, 1, 5'd3, 32'hD, 0);
        idle(3);
        // A streams with valid held high
        for (int k = 1; k <= 4; k++) step(1, 5'd7, 32'(k), 0, 5'd0, 32'd0, 0);
        idle(3);
        // write to $0 is swallowed
        step(1, 5'd0, 32'h4, 0, 5'd0, 32'd0, 0);
        idle(2);
        // fill both FIFOs then reset mid-drain
        for (int k = 0; k < 4; k++)
            step(1, 5'd10, 32'hA0 + 32'(k), 1, 5'd11, 32'hB0 + 32'(k), 0);
        step(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0, 1);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        idle(3);
        // same register from both sides with last_grant = 0
        step(1, 5'd9, 32'h1, 0, 5'd0, 32'd0, 0);
        step(1, 5'd5, 32'h11, 1, 5'd5, 32'h22, 0);
        idle(4);
        // randomized traffic with occasional resets
        rst_left = 0;
        for (int c = 0; c < 800; c++) begin
            rs = 0;
            if (rst_left > 0) begin
                rst_left--;
                rs = 1;
            end else if ($urandom_range(0, 199) == 0) begin
                rst_left = 1;
                rs = 1;
            end
            av = ($urandom_range(0, 9) < 7);
            bv = ($urandom_range(0, 9) < 6);
            ar = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                             : 5'($urandom_range(0, 7));
            br = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                             : 5'($urandom_range(0, 7));
            step(av, ar, $urandom, bv, br, $urandom, rs);
        end
        for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++)
            idle(1);
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left expected 0",
                     qa.size() + qb.size());
        end
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
